operand_latch_stage: RTL and testbench
======================================

// Module: operand_latch_stage
// PURPOSE
//  Decode->execute operand stage directly downstream of the register-file read muxes. Captures
//  the two read-port words (A, B) plus the instruction word into a 2-entry skid buffer with
//  valid/ready handshakes. Applies write-through bypass from the writeback port at capture and
//  keeps held operands coherent by snooping later writes. Output feeds the ALU/execute stage.
// PARAMETERS
//  DATA_W  32  operand width
//  ADDR_W  5   register index width (32 registers)
//  INSN_W  32  instruction payload width carried alongside operands
// PORTS
//  clock             in   1       single clock, rising edge
//  reset             in   1       synchronous, active-high
//  flush             in   1       discard all held entries (branch/exception)
//  in_valid          in   1       upstream has a decoded instruction
//  in_ready          out  1       stage can accept (registered)
//  in_insn           in   INSN_W  instruction word
//  ctrl_readRegA     in   ADDR_W  source A index driven to read mux A
//  ctrl_readRegB     in   ADDR_W  source B index driven to read mux B
//  data_readRegA     in   DATA_W  raw word from read mux A
//  data_readRegB     in   DATA_W  raw word from read mux B
//  ctrl_writeEnable  in   1       writeback write strobe
//  ctrl_writeReg     in   ADDR_W  writeback destination index
//  data_writeReg     in   DATA_W  writeback data
//  out_valid         out  1       operands valid to execute
//  out_ready         in   1       execute accepts
//  out_insn          out  INSN_W  held instruction word
//  out_opA, out_opB  out  DATA_W  held operands
// BEHAVIOUR
//  - Reset: state EMPTY; out_valid=0, in_ready=1, out_insn/out_opA/out_opB=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Latency push->out_valid: 1 cycle.
//  - States (main entry M, skid entry S):
//    EMPTY: out_valid=0, in_ready=1. push -> ONE (capture into M).
//    ONE:   out_valid=1, in_ready=1. push&!pop -> FULL (capture into S); pop&!push -> EMPTY;
//           push&pop -> ONE (new capture replaces M); neither -> ONE.
//    FULL:  out_valid=1, in_ready=0. pop -> ONE (S moves to M); else hold.
//  - in_ready is a flop: next value = (next_state != FULL).
//  - flush: highest priority after reset; next state EMPTY, out_valid=0 next cycle; an
//    in-flight push in the same cycle is dropped. Held data need not be cleared.
//  - Capture value per operand X: idx==0 -> 0; else ctrl_writeEnable & ctrl_writeReg==idx
//    -> data_writeReg; else raw data_readRegX.
//  - Snoop: each cycle, every held entry (M, S, including S moving to M) with a source index
//    equal to nonzero ctrl_writeReg under ctrl_writeEnable replaces that operand with
//    data_writeReg. Both A and B update if both match. Entry popped this cycle is don't-care.
//  - Writes to register 0 never bypass or snoop; index 0 operands always read 0.
//  - out_valid asserted with out_ready low: out_* held stable (except snoop updates).
// STRUCTURE
//  - Shared package: DATA_W/ADDR_W/INSN_W defaults, state encoding (EMPTY=2'b00, ONE=2'b01,
//    FULL=2'b10), entry record {insn, idxA, idxB, opA, opB}.
//  - Sub-module: operand_bypass_mux (combinational index-match-and-replace, zero-reg rule),
//    instantiated for capture A/B and snoop of M.A, M.B, S.A, S.B.
// TESTING
//  1 Reset then idle: out_valid=0, in_ready=1, out_opA=out_opB=0 for 5 cycles.
//  2 Push insn 0x0041_0033, A=r3 raw 0x11, B=r0 raw 0xFF, no write -> next cycle out_valid=1,
//    out_opA=0x11, out_opB=0.
//  3 Same-cycle bypass: push A=r7 raw 0x5 with write r7<=0xABCD -> out_opA=0xABCD.
//  4 Backpressure: out_ready=0, push 2 insns -> FULL, in_ready=0 next cycle; write r9<=0x77
//    while S reads r9 -> after two pops S delivers opA=0x77, order preserved.
//  5 Write to r0 with data 0xDEAD while pushing A=r0 -> out_opA=0.
//  6 FULL with flush=1 and in_valid=1 -> next cycle EMPTY, out_valid=0, in_ready=1, nothing
//    delivered.

Source files
------------

// File: rtl/operand_latch_stage_pkg.sv
// Shared definitions for the decode->execute operand latch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default widths, skid-buffer state encoding, and the held-entry record.
package operand_latch_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int INSN_W_DEF = 32;

  // Occupancy of the 2-entry skid buffer (M = main entry, S = skid entry).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // One held instruction. The source indices are kept so that later
  // writebacks can be snooped into the operands.
  typedef struct packed {
    logic [INSN_W_DEF-1:0] insn;
    logic [ADDR_W_DEF-1:0] idx_a;
    logic [ADDR_W_DEF-1:0] idx_b;
    logic [DATA_W_DEF-1:0] op_a;
    logic [DATA_W_DEF-1:0] op_b;
  } entry_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// Index-match-and-replace for one operand: register 0 reads as zero, a matching writeback wins, else raw.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   idx     in  ADDR_W  source register index of the operand
//   raw_dat in  DATA_W  value to use when no writeback matches (read-mux word or held operand)
//   wr_en   in  1       writeback strobe
//   wr_idx  in  ADDR_W  writeback destination index
//   wr_dat  in  DATA_W  writeback data
//   out_dat out DATA_W  resolved operand
module operand_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] raw_dat,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  output logic [DATA_W-1:0] out_dat
);

  always_comb begin
    out_dat = raw_dat;
    // Checking idx first also blocks writes to r0 from ever leaking through.
    if (idx == '0) begin
      out_dat = '0;
    end else if (wr_en && (wr_idx == idx)) begin
      out_dat = wr_dat;
    end
  end

endmodule

// File: rtl/operand_latch_stage.sv
// Decode->execute operand stage: 2-entry skid buffer holding insn + operands A/B, with writeback bypass and snoop.
// Latency: 1 cycle push -> out_valid.
// Backpressure: in_ready is registered and drops only when both entries are held; out_* stay stable while out_ready is low.
//
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   flush                             drop all held entries and any same-cycle push
//   in_valid/in_ready, in_insn        upstream handshake and instruction word
//   ctrl_readRegA/B, data_readRegA/B  source indices and raw read-mux words
//   ctrl_writeEnable/WriteReg, data_writeReg   writeback port (bypass + snoop source)
//   out_valid/out_ready, out_insn, out_opA/B   downstream handshake and held entry M
module operand_latch_stage
  import operand_latch_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_W = INSN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB
);

  state_t state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   in_ready_q, in_ready_d;

  logic push;
  logic pop;

  logic [DATA_W-1:0] cap_a, cap_b;
  logic [DATA_W-1:0] m_snp_a, m_snp_b, s_snp_a, s_snp_b;
  entry_t            cap_entry, m_snp, s_snp;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // Capture path: same-cycle writeback overrides the read-mux word.
  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap_a (
    .idx(ctrl_readRegA), .raw_dat(data_readRegA), .wr_en(ctrl_writeEnable),
    .wr_idx(ctrl_writeReg), .wr_dat(data_writeReg), .out_dat(cap_a)
  );
  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap_b (
    .idx(ctrl_readRegB), .raw_dat(data_readRegB), .wr_en(ctrl_writeEnable),
    .wr_idx(ctrl_writeReg), .wr_dat(data_writeReg), .out_dat(cap_b)
  );

  // Snoop path: held operands pick up writebacks that land after capture.
  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_snp_ma (
    .idx(m_q.idx_a), .raw_dat(m_q.op_a), .wr_en(ctrl_writeEnable),
    .wr_idx(ctrl_writeReg), .wr_dat(data_writeReg), .out_dat(m_snp_a)
  );
  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_snp_mb (
    .idx(m_q.idx_b), .raw_dat(m_q.op_b), .wr_en(ctrl_writeEnable),
    .wr_idx(ctrl_writeReg), .wr_dat(data_writeReg), .out_dat(m_snp_b)
  );
  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_snp_sa (
    .idx(s_q.idx_a), .raw_dat(s_q.op_a), .wr_en(ctrl_writeEnable),
    .wr_idx(ctrl_writeReg), .wr_dat(data_writeReg), .out_dat(s_snp_a)
  );
  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_snp_sb (
    .idx(s_q.idx_b), .raw_dat(s_q.op_b), .wr_en(ctrl_writeEnable),
    .wr_idx(ctrl_writeReg), .wr_dat(data_writeReg), .out_dat(s_snp_b)
  );

  always_comb begin
    cap_entry = '{insn: in_insn, idx_a: ctrl_readRegA, idx_b: ctrl_readRegB,
                  op_a: cap_a, op_b: cap_b};
    m_snp      = m_q;
    m_snp.op_a = m_snp_a;
    m_snp.op_b = m_snp_b;
    s_snp      = s_q;
    s_snp.op_a = s_snp_a;
    s_snp.op_b = s_snp_b;
  end

  // Next-state and entry update. Entries default to their snooped
  // versions so coherence holds in every state, including S->M moves.
  always_comb begin
    state_d = state_q;
    m_d     = m_snp;
    s_d     = s_snp;

    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          m_d     = cap_entry;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          state_d = ST_FULL;
          s_d     = cap_entry;
        end else if (pop && !push) begin
          state_d = ST_EMPTY;
        end else if (push && pop) begin
          m_d = cap_entry;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          m_d     = s_snp;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Held data is left as-is; only occupancy is discarded.
    if (flush) begin
      state_d = ST_EMPTY;
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign out_insn = m_q.insn;
  assign out_opA  = m_q.op_a;
  assign out_opB  = m_q.op_b;

endmodule

// File: tb/tb_operand_latch_stage.sv
// Directed bench for operand_latch_stage: reset, capture, bypass, snoop, backpressure, r0 rule, flush.
module tb_operand_latch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn, out_opA, out_opB;

  int checks = 0;
  int errors = 0;

  operand_latch_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_opA(out_opA), .out_opB(out_opB)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_in(input logic [31:0] insn, input logic [4:0] ra, input logic [31:0] da,
                         input logic [4:0] rb, input logic [31:0] db);
    in_valid      = 1'b1;
    in_insn       = insn;
    ctrl_readRegA = ra;
    data_readRegA = da;
    ctrl_readRegB = rb;
    data_readRegB = db;
  endtask

  task automatic wr(input logic en, input logic [4:0] r, input logic [31:0] d);
    ctrl_writeEnable = en;
    ctrl_writeReg    = r;
    data_writeReg    = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_insn = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0; data_readRegA = '0; data_readRegB = '0;
    wr(1'b0, 5'd0, 32'h0);
    step(); step();
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_opA", out_opA, 32'h0);
      chk("rst_opB", out_opB, 32'h0);
      step();
    end

    // 2: basic capture, B from r0
    push_in(32'h0041_0033, 5'd3, 32'h11, 5'd0, 32'hFF);
    step();
    in_valid = 1'b0;
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_insn",  out_insn, 32'h0041_0033);
    chk("cap_opA",   out_opA, 32'h11);
    chk("cap_opB",   out_opB, 32'h0);
    step();
    chk("cap_popped", 32'(out_valid), 32'd0);

    // 3: same-cycle writeback bypass
    push_in(32'h2, 5'd7, 32'h5, 5'd2, 32'h22);
    wr(1'b1, 5'd7, 32'hABCD);
    step();
    in_valid = 1'b0; wr(1'b0, 5'd0, 32'h0);
    chk("byp_opA", out_opA, 32'hABCD);
    chk("byp_opB", out_opB, 32'h22);
    step();

    // 4: backpressure, skid fill, snoop of M and S, snoop during S->M move
    out_ready = 1'b0;
    push_in(32'h10, 5'd1, 32'h100, 5'd2, 32'h200);
    step();
    chk("bp_one_ready", 32'(in_ready), 32'd1);
    push_in(32'h20, 5'd9, 32'h999, 5'd4, 32'h400);
    step();
    in_valid = 1'b0;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    chk("bp_full_insn",  out_insn, 32'h10);
    wr(1'b1, 5'd9, 32'h77);
    step();
    chk("bp_m_opA_kept", out_opA, 32'h100);
    wr(1'b1, 5'd2, 32'h2222);
    step();
    chk("bp_m_snoopB", out_opB, 32'h2222);
    chk("bp_m_insn_held", out_insn, 32'h10);
    out_ready = 1'b1;
    wr(1'b1, 5'd4, 32'h4444);
    step();
    wr(1'b0, 5'd0, 32'h0);
    chk("bp_s_insn", out_insn, 32'h20);
    chk("bp_s_opA",  out_opA, 32'h77);
    chk("bp_s_opB_move_snoop", out_opB, 32'h4444);
    chk("bp_s_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // 5: write to r0 never bypasses
    push_in(32'h5, 5'd0, 32'h55, 5'd5, 32'h5);
    wr(1'b1, 5'd0, 32'hDEAD);
    step();
    in_valid = 1'b0; wr(1'b0, 5'd0, 32'h0);
    chk("r0_opA", out_opA, 32'h0);
    chk("r0_opB", out_opB, 32'h5);
    step();

    // push and pop in the same cycle from ONE replaces M
    push_in(32'h31, 5'd6, 32'h6, 5'd8, 32'h8);
    step();
    push_in(32'h32, 5'd10, 32'hA, 5'd11, 32'hB);
    step();
    in_valid = 1'b0;
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_insn",  out_insn, 32'h32);
    chk("pp_opA",   out_opA, 32'hA);
    chk("pp_ready", 32'(in_ready), 32'd1);
    step();
    chk("pp_drained", 32'(out_valid), 32'd0);

    // 6: flush while FULL with a push pending
    out_ready = 1'b0;
    push_in(32'h41, 5'd1, 32'h1, 5'd2, 32'h2);
    step();
    push_in(32'h42, 5'd3, 32'h3, 5'd4, 32'h4);
    step();
    chk("fl_full_ready", 32'(in_ready), 32'd0);
    push_in(32'h43, 5'd5, 32'h5, 5'd6, 32'h6);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_nothing_delivered", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
